cmp_stream_unit: RTL and testbench

- Parametrised comparator for the Basic ALU datapath with a registered valid/ready output stage.
- Supports per-transaction signed or unsigned mode.
- Supports eight operations: LT, LE, EQ, NE, GT, GE, MIN and MAX.
- Tracks running min/max statistics over operand A for every accepted transaction.
- Sits between the operand mux and the ALU result mux, and replaces the fixed 6-bit signed less-than path.

---
 rtl/cmp_stream_unit_if.sv | 26 ++
 rtl/cmp_stream_unit.sv | 149 ++++++++++++++
 tb/tb_cmp_stream_unit.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/cmp_stream_unit_if.sv
// Operand/result stream interface for cmp_stream_unit.
// The master drives operands and accepts results; the slave is the comparator.
interface cmp_stream_unit_if #(
    parameter int unsigned WIDTH = 6
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [2:0]       op;
    logic             is_signed;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [2:0]       flags;

    modport master (
        output in_valid, in_a, in_b, op, is_signed, out_ready,
        input  in_ready, out_valid, result, flags
    );

    modport slave (
        input  in_valid, in_a, in_b, op, is_signed, out_ready,
        output in_ready, out_valid, result, flags
    );
endinterface

// File: rtl/cmp_stream_unit.sv
// Signed/unsigned comparator with a registered valid/ready result stage
// and running min/max/count statistics over operand A.
module cmp_stream_unit #(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    cmp_stream_unit_if.slave   bus,
    input  logic               clr_stats,
    output logic [WIDTH-1:0]   run_min,
    output logic [WIDTH-1:0]   run_max,
    output logic [CNT_W-1:0]   stat_count
);

    typedef enum logic [2:0] {
        OP_LT  = 3'b000,
        OP_LE  = 3'b001,
        OP_EQ  = 3'b010,
        OP_NE  = 3'b011,
        OP_GT  = 3'b100,
        OP_GE  = 3'b101,
        OP_MIN = 3'b110,
        OP_MAX = 3'b111
    } op_e;

    typedef enum logic {
        ST_EMPTY,
        ST_ACTIVE
    } stat_state_e;

    // Returns {gt, eq, lt}. Signed mode flips the sign bit so an unsigned
    // compare orders two's-complement values exactly, with no negation.
    function automatic logic [2:0] compare(input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b,
                                           input logic             sgn);
        logic [WIDTH-1:0] ka;
        logic [WIDTH-1:0] kb;
        ka = a;
        kb = b;
        if (sgn) begin
            ka[WIDTH-1] = ~a[WIDTH-1];
            kb[WIDTH-1] = ~b[WIDTH-1];
        end
        return {ka > kb, ka == kb, ka < kb};
    endfunction

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [2:0]       flags_q, flags_d;
    logic [WIDTH-1:0] run_min_q, run_min_d;
    logic [WIDTH-1:0] run_max_q, run_max_d;
    logic [CNT_W-1:0] stat_count_q, stat_count_d;
    stat_state_e      stat_state_q, stat_state_d;

    logic             in_ready;
    logic             accept;
    logic [2:0]       cur_flags;
    logic [2:0]       min_flags;
    logic [2:0]       max_flags;

    assign in_ready      = !out_valid_q || bus.out_ready;
    assign accept        = bus.in_valid && in_ready;
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.flags     = flags_q;
    assign run_min       = run_min_q;
    assign run_max       = run_max_q;
    assign stat_count    = stat_count_q;

    // Result stage: load on accept, drop valid on release without a new accept.
    always_comb begin
        cur_flags   = compare(bus.in_a, bus.in_b, bus.is_signed);
        out_valid_d = out_valid_q;
        result_d    = result_q;
        flags_d     = flags_q;
        if (accept) begin
            out_valid_d = 1'b1;
            flags_d     = cur_flags;
            case (op_e'(bus.op))
                OP_LT:  result_d = WIDTH'(cur_flags[0]);
                OP_LE:  result_d = WIDTH'(cur_flags[0] | cur_flags[1]);
                OP_EQ:  result_d = WIDTH'(cur_flags[1]);
                OP_NE:  result_d = WIDTH'(!cur_flags[1]);
                OP_GT:  result_d = WIDTH'(cur_flags[2]);
                OP_GE:  result_d = WIDTH'(cur_flags[2] | cur_flags[1]);
                OP_MIN: result_d = cur_flags[2] ? bus.in_b : bus.in_a;
                OP_MAX: result_d = cur_flags[0] ? bus.in_b : bus.in_a;
            endcase
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Statistics next state: clear first, then a same-cycle sample loads on top.
    always_comb begin
        min_flags    = compare(bus.in_a, run_min_q, bus.is_signed);
        max_flags    = compare(bus.in_a, run_max_q, bus.is_signed);
        stat_state_d = stat_state_q;
        run_min_d    = run_min_q;
        run_max_d    = run_max_q;
        stat_count_d = stat_count_q;
        if (clr_stats) begin
            stat_state_d = ST_EMPTY;
            run_min_d    = '0;
            run_max_d    = '0;
            stat_count_d = '0;
        end
        if (accept) begin
            if (stat_state_d == ST_EMPTY) begin
                stat_state_d = ST_ACTIVE;
                run_min_d    = bus.in_a;
                run_max_d    = bus.in_a;
                stat_count_d = CNT_W'(1);
            end else begin
                if (min_flags[0]) run_min_d = bus.in_a;
                if (max_flags[2]) run_max_d = bus.in_a;
                if (stat_count_q != '1) stat_count_d = stat_count_q + CNT_W'(1);
            end
        end
    end

    // Statistics state register.
    always_ff @(posedge clk) begin
        if (rst) stat_state_q <= ST_EMPTY;
        else     stat_state_q <= stat_state_d;
    end

    // Result and statistics data registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            result_q     <= '0;
            flags_q      <= '0;
            run_min_q    <= '0;
            run_max_q    <= '0;
            stat_count_q <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            result_q     <= result_d;
            flags_q      <= flags_d;
            run_min_q    <= run_min_d;
            run_max_q    <= run_max_d;
            stat_count_q <= stat_count_d;
        end
    end

endmodule

// File: tb/tb_cmp_stream_unit.sv
// Directed self-checking bench for cmp_stream_unit (WIDTH=6; CNT_W=8 and CNT_W=2).
module tb_cmp_stream_unit;

    logic       clk;
    logic       rst;
    logic       clr_stats;
    logic [5:0] run_min, run_max;
    logic [7:0] stat_count;
    logic       clr2;
    logic [5:0] run_min2, run_max2;
    logic [1:0] stat_count2;

    int n_checks = 0;
    int n_fail   = 0;

    cmp_stream_unit_if #(.WIDTH(6)) bus ();
    cmp_stream_unit_if #(.WIDTH(6)) bus2 ();

    cmp_stream_unit #(.WIDTH(6), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .bus(bus), .clr_stats(clr_stats),
        .run_min(run_min), .run_max(run_max), .stat_count(stat_count)
    );

    cmp_stream_unit #(.WIDTH(6), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .bus(bus2), .clr_stats(clr2),
        .run_min(run_min2), .run_max(run_max2), .stat_count(stat_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] a, input logic [5:0] b,
                         input logic [2:0] o, input logic s);
        bus.in_valid  = v;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.op        = o;
        bus.is_signed = s;
    endtask

    task automatic check_out(input string tag, input logic [5:0] res, input logic [2:0] fl);
        check({tag, ".valid"}, bus.out_valid, 1'b1);
        check({tag, ".result"}, bus.result, res);
        check({tag, ".flags"}, bus.flags, fl);
    endtask

    task automatic check_stats(input string tag, input logic [5:0] mn, input logic [5:0] mx,
                               input logic [7:0] cnt);
        check({tag, ".min"}, run_min, mn);
        check({tag, ".max"}, run_max, mx);
        check({tag, ".count"}, stat_count, cnt);
    endtask

    initial begin
        rst = 1'b1;
        clr_stats = 1'b0;
        clr2 = 1'b0;
        drive(1'b0, '0, '0, 3'd0, 1'b0);
        bus.out_ready = 1'b1;
        bus2.in_valid = 1'b0;
        bus2.in_a = '0;
        bus2.in_b = '0;
        bus2.op = 3'd0;
        bus2.is_signed = 1'b0;
        bus2.out_ready = 1'b1;
        step();
        step();
        check("rst.valid", bus.out_valid, 1'b0);
        check("rst.result", bus.result, 6'd0);
        check("rst.flags", bus.flags, 3'b000);
        check_stats("rst", 6'd0, 6'd0, 8'd0);
        rst = 1'b0;

        // Most-negative vs most-positive, signed then unsigned
        drive(1'b1, 6'b100000, 6'b011111, 3'b000, 1'b1);
        step();
        check_out("lt_signed", 6'd1, 3'b001);
        check_stats("first", 6'h20, 6'h20, 8'd1);
        drive(1'b1, 6'b100000, 6'b011111, 3'b000, 1'b0);
        step();
        check_out("lt_unsigned", 6'd0, 3'b100);

        // Equal negative operands
        drive(1'b1, 6'b111010, 6'b111010, 3'b001, 1'b1);
        step();
        check_out("le_eq", 6'd1, 3'b010);
        drive(1'b1, 6'b111010, 6'b111010, 3'b011, 1'b1);
        step();
        check_out("ne_eq", 6'd0, 3'b010);
        drive(1'b1, 6'b111010, 6'b111010, 3'b110, 1'b1);
        step();
        check_out("min_eq", 6'b111010, 3'b010);
        check_stats("eqneg", 6'h20, 6'h3A, 8'd5);

        // Remaining operations
        drive(1'b1, 6'd9, 6'd5, 3'b100, 1'b0);
        step();
        check_out("gt", 6'd1, 3'b100);
        drive(1'b1, 6'h3F, 6'h01, 3'b101, 1'b1);
        step();
        check_out("ge_neg", 6'd0, 3'b001);
        drive(1'b1, 6'd7, 6'd7, 3'b010, 1'b0);
        step();
        check_out("eq", 6'd1, 3'b010);
        drive(1'b1, 6'h3F, 6'h01, 3'b111, 1'b1);
        step();
        check_out("max_s", 6'h01, 3'b001);
        drive(1'b1, 6'h3F, 6'h01, 3'b111, 1'b0);
        step();
        check_out("max_u", 6'h3F, 3'b100);
        drive(1'b1, 6'h3F, 6'h01, 3'b110, 1'b0);
        step();
        check_out("min_u", 6'h01, 3'b100);

        // Backpressure, with a stats clear on the first accept
        clr_stats = 1'b1;
        drive(1'b1, 6'd5, 6'd9, 3'b111, 1'b0);
        step();
        clr_stats = 1'b0;
        check_out("bp_load", 6'd9, 3'b001);
        check_stats("bp_load", 6'd5, 6'd5, 8'd1);
        bus.out_ready = 1'b0;
        drive(1'b1, 6'd1, 6'd2, 3'b000, 1'b0);
        #1;
        check("bp.in_ready", bus.in_ready, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_out("bp_hold", 6'd9, 3'b001);
            check("bp_hold.in_ready", bus.in_ready, 1'b0);
            check("bp_hold.count", stat_count, 8'd1);
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp_rel.in_ready", bus.in_ready, 1'b1);
        step();
        check_out("bp_next", 6'd1, 3'b001);
        check_stats("bp_next", 6'd1, 6'd5, 8'd2);

        // Drain and clear, then stream signed 3, -7, 12, 0 against B=0
        drive(1'b0, '0, '0, 3'b000, 1'b0);
        clr_stats = 1'b1;
        step();
        clr_stats = 1'b0;
        check("drain.valid", bus.out_valid, 1'b0);
        check_stats("clr", 6'd0, 6'd0, 8'd0);
        drive(1'b1, 6'd3, 6'd0, 3'b000, 1'b1);
        step();
        check_out("s0", 6'd0, 3'b100);
        drive(1'b1, 6'b111001, 6'd0, 3'b000, 1'b1);
        step();
        check_out("s1", 6'd1, 3'b001);
        drive(1'b1, 6'd12, 6'd0, 3'b000, 1'b1);
        step();
        check_out("s2", 6'd0, 3'b100);
        drive(1'b1, 6'd0, 6'd0, 3'b000, 1'b1);
        step();
        check_out("s3", 6'd0, 3'b010);
        check_stats("stream", 6'b111001, 6'd12, 8'd4);
        drive(1'b0, '0, '0, 3'b000, 1'b0);
        step();
        check("stream_end.valid", bus.out_valid, 1'b0);

        // Clear together with an accept of -2, then clear alone
        clr_stats = 1'b1;
        drive(1'b1, 6'b111110, 6'd0, 3'b000, 1'b1);
        step();
        check_stats("clr_acc", 6'b111110, 6'b111110, 8'd1);
        drive(1'b0, '0, '0, 3'b000, 1'b0);
        step();
        clr_stats = 1'b0;
        check_stats("clr_only", 6'd0, 6'd0, 8'd0);

        // Saturating counter on the CNT_W=2 instance
        bus2.in_valid = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            bus2.in_a = 6'(i);
            step();
            check("sat.count", stat_count2, (i < 3) ? i : 3);
        end
        bus2.in_valid = 1'b0;
        check("sat.min", run_min2, 6'd1);
        check("sat.max", run_max2, 6'd5);

        // Reset while a result is stalled
        drive(1'b1, 6'h15, 6'h03, 3'b100, 1'b0);
        step();
        check_out("pre_rst", 6'd1, 3'b100);
        bus.out_ready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(1'b0, '0, '0, 3'b000, 1'b0);
        check("mid_rst.valid", bus.out_valid, 1'b0);
        check("mid_rst.result", bus.result, 6'd0);
        check("mid_rst.flags", bus.flags, 3'b000);
        check_stats("mid_rst", 6'd0, 6'd0, 8'd0);
        check("mid_rst.in_ready", bus.in_ready, 1'b1);
        check("mid_rst.sat_count", stat_count2, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
